approx_mult_pipe: RTL and testbench
===================================

Name: approx_mult_pipe

Overview:
- Parametrised, pipelined unsigned multiplier with a per-transaction exact/approximate mode.
- Approximate mode drops the low partial-product columns.
- Successor to the fixed 8-bit approximate multiplier datapath; feeds board-level display/logging wrappers.
- Adds a valid/ready stream handshake with backpressure, configurable width, truncation depth and pipeline depth.

Parameters:
- W, 8, operand width in bits (4..32); product width is 2*W.
- K, 4, number of low partial-product columns dropped in approximate mode (0..2*W-1).
- STAGES, 3, pipeline latency in cycles (1..8).
- CNT_W, 16, width of the error-statistics counters (optional feature only).

Ports:
- CLK_100MHZ  input  1  system clock, all state on rising edge
- RST_N  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts operands this cycle
- in_a  input  W  operand A, unsigned
- in_b  input  W  operand B, unsigned
- in_mode  input  1  0 = exact, 1 = approximate
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_product  output  2*W  product
- out_mode  output  1  mode the result was computed in
- err_sum  output  2*CNT_W  accumulated (exact - approx); optional feature only
- err_count  output  CNT_W  approximate samples counted; optional feature only
- stats_clr  input  1  synchronous clear of statistics; optional feature only

Behaviour:
- Exact result: in_a * in_b.
- Approximate result: sum over i,j of a[i]&b[j] << (i+j), only for i+j >= K. K=0 means approximate equals exact.
- The approximate result is always <= the exact result.
- Pipeline: STAGES register stages, each holding valid, mode and partial data.
- Global advance enable: adv = out_ready | ~out_valid.
- in_ready = adv, combinational.
- Transfer on in_valid & in_ready.
- When adv = 1:
  - every stage shifts forward;
  - stage 0 valid loads in_valid & in_ready.
- When adv = 0: every stage holds.
- Latency: a result accepted in cycle t appears on out_valid in cycle t+STAGES if no stall occurs. Each stall cycle adds one.
- Bubbles are not compressed. Throughput is 1 result/cycle with out_ready held high.
- Outputs are stable while out_valid & ~out_ready: out_product and out_mode must not change.
- Ordering is strictly FIFO; no reordering, no drop, no duplication.
- Simultaneous in_valid and output stall: the input is not accepted (in_ready = 0). The upstream holds its data.
- Reset (RST_N low, any time, including mid-stream):
  - all stage valids = 0, out_valid = 0, out_product = 0, out_mode = 0;
  - in-flight data discarded;
  - in_ready = 1 after reset, since out_valid = 0.
- Outputs come directly from final-stage registers; no combinational path from in_* to out_*.
- Partial-product reduction split across stages is implementation choice. The result must be bit-identical to the formula above.

Optional Feature:
- Macro: APPROX_MULT_ERR_STATS_EN.
- Defined:
  - the block computes the exact product alongside every approximate-mode transaction;
  - on each output handshake (out_valid & out_ready) with out_mode = 1, err_sum += exact - approx and err_count += 1;
  - both counters saturate at all-ones; no wrap;
  - stats_clr zeroes both counters the next cycle; clear wins over a simultaneous update;
  - reset value is 0.
- Undefined:
  - err_sum, err_count and stats_clr are absent from the port list;
  - no exact shadow path is built.

Test Plan:
- W=8, K=4, in_mode=1, a=255, b=255, out_ready=1 -> out_product=64976 (exact 65025 minus 49) after exactly 3 cycles.
- Same operands with in_mode=0 -> 65025, out_mode=0. a=3, b=3 approx -> 0. a=16, b=16 approx -> 256.
- Back-to-back stream of 10 random pairs, out_ready=1 -> 10 results in order, one per cycle, all matching the reference model.
- out_ready low for 5 cycles with a full pipeline -> in_ready=0, outputs held constant, no loss. Release -> remaining results drain in order.
- Assert RST_N low with 2 results in flight -> out_valid=0 immediately (async), out_product=0. After release, no stale results appear.
- With APPROX_MULT_ERR_STATS_EN: 255x255 approx three times -> err_sum=147, err_count=3. Exact-mode transactions do not change the counters. stats_clr -> both 0 next cycle.

Source files
------------

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: pipelined unsigned W x W multiplier with a per-transaction
// exact/approximate mode. In approximate mode, partial-product bits whose
// column i+j is below K are dropped. The product is formed in front of stage 0.
// The STAGES registers then carry it, together with valid and mode, toward the
// output. A single advance enable moves the whole pipe or freezes it.
//
// Optional build macro: APPROX_MULT_ERR_STATS_EN adds saturating error
// statistics (err_sum, err_count, stats_clr) fed by an exact shadow path.
module approx_mult_pipe #(
  parameter int W      = 8,
  parameter int K      = 4,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic           CLK_100MHZ,
  input  logic           RST_N,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           out_mode
`ifdef APPROX_MULT_ERR_STATS_EN
  ,
  output logic [2*CNT_W-1:0] err_sum,
  output logic [CNT_W-1:0]   err_count,
  input  logic               stats_clr
`endif
);

  localparam int P = 2 * W;

  if (W < 4 || W > 32) begin : g_bad_w
    $error("approx_mult_pipe: W must be 4..32");
  end
  if (K < 0 || K > P - 1) begin : g_bad_k
    $error("approx_mult_pipe: K must be 0..2*W-1");
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("approx_mult_pipe: STAGES must be 1..8");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("approx_mult_pipe: CNT_W must be positive");
  end

  logic         adv;
  logic [P-1:0] exact;
  logic [P-1:0] approx;
  logic [P-1:0] prod_in;
  logic [W-1:0] row;

  logic         vld  [STAGES];
  logic         mode [STAGES];
  logic [P-1:0] prod [STAGES];

  // The whole pipe advances when the output slot is empty or being drained.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign exact = P'(in_a) * P'(in_b);

  // Sum the partial-product rows, keeping only bits in columns i+j >= K.
  always_comb begin
    approx = '0;
    row    = '0;
    for (int i = 0; i < W; i++) begin
      row = '0;
      for (int j = 0; j < W; j++) begin
        if (i + j >= K) row[j] = in_a[i] & in_b[j];
      end
      approx = approx + (P'(row) << i);
    end
  end

  assign prod_in = in_mode ? approx : exact;

  // Pipeline registers: every stage shifts together on adv and holds otherwise.
  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k]  <= 1'b0;
        mode[k] <= 1'b0;
        prod[k] <= '0;
      end
    end else if (adv) begin
      vld[0]  <= in_valid & in_ready;
      mode[0] <= in_mode;
      prod[0] <= prod_in;
      for (int k = 1; k < STAGES; k++) begin
        vld[k]  <= vld[k-1];
        mode[k] <= mode[k-1];
        prod[k] <= prod[k-1];
      end
    end
  end

  assign out_valid   = vld[STAGES-1];
  assign out_mode    = mode[STAGES-1];
  assign out_product = prod[STAGES-1];

`ifdef APPROX_MULT_ERR_STATS_EN
  localparam int SW = ((2 * CNT_W > P) ? 2 * CNT_W : P) + 1;

  logic [P-1:0]       diff [STAGES];
  logic [SW-1:0]      sum_wide;
  logic [SW-1:0]      sum_max;
  logic [2*CNT_W-1:0] sum_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               stat_upd;

  // Shadow path carrying exact - approx alongside each transaction.
  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < STAGES; k++) diff[k] <= '0;
    end else if (adv) begin
      diff[0] <= exact - approx;
      for (int k = 1; k < STAGES; k++) diff[k] <= diff[k-1];
    end
  end

  assign stat_upd = out_valid & out_ready & out_mode;

  // Saturating next values; the sum is widened so overflow is visible.
  always_comb begin
    sum_wide  = SW'(err_sum) + SW'(diff[STAGES-1]);
    sum_max   = SW'({(2 * CNT_W){1'b1}});
    sum_nxt   = (sum_wide > sum_max) ? {(2 * CNT_W){1'b1}} : sum_wide[2*CNT_W-1:0];
    count_nxt = (&err_count) ? err_count : err_count + 1'b1;
  end

  // Statistics counters; a clear takes priority over a same-cycle update.
  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      err_sum   <= '0;
      err_count <= '0;
    end else if (stats_clr) begin
      err_sum   <= '0;
      err_count <= '0;
    end else if (stat_upd) begin
      err_sum   <= sum_nxt;
      err_count <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe (W=8, K=4, STAGES=3).
module tb_approx_mult_pipe;

  localparam int W = 8;
  localparam int K = 4;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_product;
  logic           out_mode;
`ifdef APPROX_MULT_ERR_STATS_EN
  logic [31:0]    err_sum;
  logic [15:0]    err_count;
  logic           stats_clr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  approx_mult_pipe #(.W(W), .K(K), .STAGES(S), .CNT_W(16)) dut (
    .CLK_100MHZ (clk),
    .RST_N      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product),
    .out_mode   (out_mode)
`ifdef APPROX_MULT_ERR_STATS_EN
    ,
    .err_sum    (err_sum),
    .err_count  (err_count),
    .stats_clr  (stats_clr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: exact product minus every dropped low-column bit.
  function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b,
                                           input logic m);
    int unsigned e;
    int unsigned lost;
    e    = a * b;
    lost = 0;
    if (m) begin
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++)
          if (i + j < K && a[i] && b[j]) lost += (1 << (i + j));
    end
    return 16'(e - lost);
  endfunction

  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic m,
                          input logic [15:0] expv, input string tag);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_a      = a;
    in_b      = b;
    in_mode   = m;
    in_valid  = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, S);
    chk({tag, "_product"}, out_product, expv);
    chk({tag, "_mode"}, out_mode, m);
    @(negedge clk);
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  task automatic run_stream(input int n, input int stall_start, input int stall_len,
                            input string tag);
    logic [15:0] exp_q[$];
    logic        mode_q[$];
    logic [15:0] held;
    logic        held_m;
    logic        held_v;
    logic [7:0]  ca, cb;
    logic        cm;
    logic        have;
    int          sent, got, first, last;
    sent = 0; got = 0; first = -1; last = -1;
    held_v = 1'b0; held = '0; held_m = 1'b0; have = 1'b0;
    ca = '0; cb = '0; cm = 1'b0;
    for (int cyc = 0; cyc < n + stall_len + 20; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      #1;
      if (held_v) begin
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_product"}, out_product, held);
        chk({tag, "_hold_mode"}, out_mode, held_m);
      end
      held_v = out_valid && !out_ready;
      held   = out_product;
      held_m = out_mode;
      if (cyc == stall_start && stall_len > 0) chk({tag, "_stall_in_ready"}, in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_unexpected_out"}, 1, 0);
        end else begin
          chk({tag, "_product"}, out_product, exp_q.pop_front());
          chk({tag, "_mode"}, out_mode, mode_q.pop_front());
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (sent < n) begin
        if (!have) begin
          ca   = 8'($urandom);
          cb   = 8'($urandom);
          cm   = 1'($urandom_range(0, 1));
          have = 1'b1;
        end
        in_a     = ca;
        in_b     = cb;
        in_mode  = cm;
        in_valid = 1'b1;
        if (in_ready) begin
          exp_q.push_back(ref_mult(ca, cb, cm));
          mode_q.push_back(cm);
          sent++;
          have = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk({tag, "_count"}, got, n);
    chk({tag, "_left"}, exp_q.size(), 0);
    if (stall_len == 0) chk({tag, "_back_to_back"}, last - first, n - 1);
  endtask

  initial begin
    int stale;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
`ifdef APPROX_MULT_ERR_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_product", out_product, 0);
    chk("reset_out_mode", out_mode, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send_one(8'd255, 8'd255, 1'b1, 16'd64976, "ff_approx");
    send_one(8'd255, 8'd255, 1'b0, 16'd65025, "ff_exact");
    send_one(8'd3,   8'd3,   1'b1, 16'd0,     "3x3_approx");
    send_one(8'd16,  8'd16,  1'b1, 16'd256,   "16x16_approx");
    send_one(8'd15,  8'd15,  1'b1, 16'd176,   "15x15_approx");
    send_one(8'd0,   8'd200, 1'b1, 16'd0,     "zero_approx");
    send_one(8'd13,  8'd11,  1'b0, 16'd143,   "13x11_exact");

    run_stream(10, 1000, 0, "stream");
    run_stream(8, 6, 5, "stall");

    @(negedge clk);
    out_ready = 1'b0;
    in_a = 8'd255; in_b = 8'd255; in_mode = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_a = 8'd16; in_b = 8'd16; in_mode = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk("rst_pre_valid", out_valid, 1);
    chk("rst_pre_product", out_product, 16'd64976);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_product", out_product, 0);
    chk("rst_async_mode", out_mode, 0);
    chk("rst_async_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst_no_stale", stale, 0);

`ifdef APPROX_MULT_ERR_STATS_EN
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("stats_init_sum", err_sum, 0);
    repeat (3) send_one(8'd255, 8'd255, 1'b1, 16'd64976, "stats_ff");
    chk("stats_sum", err_sum, 147);
    chk("stats_count", err_count, 3);
    send_one(8'd255, 8'd255, 1'b0, 16'd65025, "stats_exact");
    chk("stats_sum_exact", err_sum, 147);
    chk("stats_count_exact", err_count, 3);
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("stats_clr_sum", err_sum, 0);
    chk("stats_clr_count", err_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
